// File: rtl/beam_steer_ctrl.sv
// Beam-steering controller: turns an angle code into a per-channel delay-line tap table.
// The table is written one entry per cycle from an add/subtract accumulator, and the array outputs are blanked until it has settled.
module beam_steer_ctrl #(
    parameter int NUM_CH        = 20,
    parameter int MAX_TAP       = 8500,
    parameter int SETTLE_CYCLES = 8500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  angle_sel,
    input  logic        angle_valid,
    output logic        angle_ready,
    output logic        tap_we,
    output logic [4:0]  tap_ch,
    output logic [13:0] tap_idx,
    output logic        out_en,
    output logic        cfg_done,
    output logic [3:0]  cur_sel
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [3:0]       CODE_ZERO   = 4'd6;
    localparam logic [3:0]       CODE_MAX    = 4'd12;
    localparam logic [4:0]       LAST_CH     = 5'(NUM_CH - 1);
    localparam logic [4:0]       CH_ONE      = 5'd1;
    localparam logic [13:0]      MAX_TAP_V   = 14'(MAX_TAP);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        SETTLE
    } state_e;

    // Per-channel tap step for each angle code; the sign comes from the direction flag.
    function automatic logic [13:0] step_for(input logic [3:0] code);
        logic [13:0] step;
        case (code)
            4'd0, 4'd12: step = 14'd430;
            4'd1, 4'd11: step = 14'd359;
            4'd2, 4'd10: step = 14'd287;
            4'd3, 4'd9:  step = 14'd215;
            4'd4, 4'd8:  step = 14'd143;
            4'd5, 4'd7:  step = 14'd72;
            default:     step = 14'd0;
        endcase
        return step;
    endfunction

    state_e           state_q;
    logic             boot_q;
    logic             ready_q;
    logic             tap_we_q;
    logic [4:0]       tap_ch_q;
    logic [13:0]      tap_idx_q;
    logic             out_en_q;
    logic             cfg_done_q;
    logic [3:0]       cur_sel_q;
    logic [13:0]      step_q;
    logic             neg_q;
    logic [13:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  eff_sel_d;
    logic [3:0]  load_sel_d;
    logic        load_neg_d;
    logic        same_cfg_d;
    logic [13:0] acc_d;

    always_comb begin
        eff_sel_d  = (angle_sel > CODE_MAX) ? CODE_ZERO : angle_sel;
        load_sel_d = boot_q ? CODE_ZERO : eff_sel_d;
        load_neg_d = (load_sel_d < CODE_ZERO);
        same_cfg_d = (eff_sel_d == cur_sel_q) && out_en_q;
        acc_d      = neg_q ? (acc_q - step_q) : (acc_q + step_q);
    end

    // NOTE: all state below is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            boot_q     <= 1'b1;
            ready_q    <= 1'b0;
            tap_we_q   <= 1'b0;
            tap_ch_q   <= '0;
            tap_idx_q  <= '0;
            out_en_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            cur_sel_q  <= CODE_ZERO;
            step_q     <= '0;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
        end else begin
            cfg_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The post-reset auto-load borrows the normal load path with the angle-0 code.
                    if (boot_q || (angle_valid && ready_q && !same_cfg_d)) begin
                        state_q   <= LOAD;
                        boot_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        out_en_q  <= 1'b0;
                        cur_sel_q <= load_sel_d;
                        step_q    <= step_for(load_sel_d);
                        neg_q     <= load_neg_d;
                        acc_q     <= load_neg_d ? MAX_TAP_V : '0;
                    end else if (angle_valid && ready_q) begin
                        cfg_done_q <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q   <= WRITE;
                    tap_we_q  <= 1'b1;
                    tap_ch_q  <= '0;
                    tap_idx_q <= acc_q;
                    acc_q     <= acc_d;
                end
                WRITE: begin
                    if (tap_ch_q == LAST_CH) begin
                        state_q   <= SETTLE;
                        tap_we_q  <= 1'b0;
                        tap_ch_q  <= '0;
                        tap_idx_q <= '0;
                        cnt_q     <= SETTLE_LOAD;
                    end else begin
                        tap_ch_q  <= tap_ch_q + CH_ONE;
                        tap_idx_q <= acc_q;
                        acc_q     <= acc_d;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q    <= IDLE;
                        ready_q    <= 1'b1;
                        out_en_q   <= 1'b1;
                        cfg_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign angle_ready = ready_q;
    assign tap_we      = tap_we_q;
    assign tap_ch      = tap_ch_q;
    assign tap_idx     = tap_idx_q;
    assign out_en      = out_en_q;
    assign cfg_done    = cfg_done_q;
    assign cur_sel     = cur_sel_q;

endmodule
